// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } ch_state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // Wide enough for any DIV_WIDTH up to 32; callers cast down to their width.
    typedef logic [31:0] div_word_t;

    typedef struct packed {
        div_word_t period;
        div_word_t high;
    } cfg_word_t;

    // Clamp a requested (period, high) pair into a legal waveform.
    function automatic cfg_word_t sanitise_cfg(input div_word_t p, input div_word_t h);
        cfg_word_t cfg;
        cfg.period = (p < div_word_t'(MIN_PERIOD)) ? div_word_t'(MIN_PERIOD) : p;
        cfg.high   = (h == '0) ? div_word_t'(1) : h;
        if (cfg.high >= cfg.period) begin
            cfg.high = cfg.period - div_word_t'(1);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: run/stop FSM, period counter, active/shadow config, edge ticks.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 load,
    input  logic                 sync,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic [DIV_WIDTH-1:0] high_in,
    output logic                 clk_out,
    output logic                 rise_tick,
    output logic                 fall_tick,
    output logic                 busy,
    output logic                 cfg_pending
);

    localparam int unsigned          DEF_H_INT = (DEFAULT_DIV / 2 < 1) ? 1 : DEFAULT_DIV / 2;
    localparam logic [DIV_WIDTH-1:0] DEF_P     = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DEF_H     = DIV_WIDTH'(DEF_H_INT);
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

    ch_state_t            state;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] act_p, act_h, sh_p, sh_h;

    cfg_word_t            san;
    logic [DIV_WIDTH-1:0] san_p, san_h;
    logic [DIV_WIDTH-1:0] eff_p, eff_h, high_next, cnt_next;
    logic                 wrap, clk_next;

    // Sanitise the incoming configuration words.
    always_comb begin
        san   = sanitise_cfg(div_word_t'(div_in), div_word_t'(high_in));
        san_p = DIV_WIDTH'(san.period);
        san_h = DIV_WIDTH'(san.high);
    end

    // Next count and output level; a wrap switches to the shadow config so the new
    // period's first high phase is already judged against the new high time.
    always_comb begin
        wrap      = sync || (cnt == act_p - ONE);
        eff_p     = cfg_pending ? sh_p : act_p;
        eff_h     = cfg_pending ? sh_h : act_h;
        cnt_next  = wrap ? '0 : cnt + ONE;
        high_next = wrap ? eff_h : act_h;
        clk_next  = (cnt_next < high_next);
    end

    assign busy = (state != IDLE);

    // Channel FSM with counter, config registers and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            act_p       <= DEF_P;
            act_h       <= DEF_H;
            sh_p        <= DEF_P;
            sh_h        <= DEF_H;
            cfg_pending <= 1'b0;
            clk_out     <= 1'b0;
            rise_tick   <= 1'b0;
            fall_tick   <= 1'b0;
        end else begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        act_p <= san_p;
                        act_h <= san_h;
                        sh_p  <= san_p;
                        sh_h  <= san_h;
                    end
                    if (enable) begin
                        state     <= RUN;
                        cnt       <= '0;
                        clk_out   <= 1'b1;
                        rise_tick <= 1'b1;
                    end
                end
                default: begin
                    if (wrap) begin
                        act_p       <= eff_p;
                        act_h       <= eff_h;
                        cfg_pending <= 1'b0;
                    end
                    if (state == STOPPING && !enable && wrap) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        clk_out   <= 1'b0;
                        fall_tick <= clk_out;
                    end else begin
                        state     <= enable ? RUN : STOPPING;
                        cnt       <= cnt_next;
                        clk_out   <= clk_next;
                        rise_tick <= clk_next & ~clk_out;
                        fall_tick <= ~clk_next & clk_out;
                    end
                    // A load landing on a wrap edge goes to the shadow after the swap.
                    if (load) begin
                        sh_p        <= san_p;
                        sh_h        <= san_h;
                        cfg_pending <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: slices the buses and fans out sync.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           enable,
    input  logic [NUM_CH-1:0]           load,
    input  logic [NUM_CH*DIV_WIDTH-1:0] div_in,
    input  logic [NUM_CH*DIV_WIDTH-1:0] high_in,
    input  logic                        sync,
    output logic [NUM_CH-1:0]           clk_out,
    output logic [NUM_CH-1:0]           rise_tick,
    output logic [NUM_CH-1:0]           fall_tick,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           cfg_pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_channel #(
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .enable      (enable[i]),
            .load        (load[i]),
            .sync        (sync),
            .div_in      (div_in[i*DIV_WIDTH +: DIV_WIDTH]),
            .high_in     (high_in[i*DIV_WIDTH +: DIV_WIDTH]),
            .clk_out     (clk_out[i]),
            .rise_tick   (rise_tick[i]),
            .fall_tick   (fall_tick[i]),
            .busy        (busy[i]),
            .cfg_pending (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: directed scenarios plus random traffic,
// every cycle compared against a behavioural per-channel waveform model.
module tb_clock_divider_multi;

    localparam int NUM_CH = 2;
    localparam int DW     = 16;
    localparam int DEF    = 10;

    logic                 clk;
    logic                 rst;
    logic [NUM_CH-1:0]    enable, load;
    logic [NUM_CH*DW-1:0] div_in, high_in;
    logic                 sync;
    logic [NUM_CH-1:0]    clk_out, rise_tick, fall_tick, busy, cfg_pending;

    int checks = 0;
    int errors = 0;

    clock_divider_multi #(
        .NUM_CH      (NUM_CH),
        .DIV_WIDTH   (DW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load        (load),
        .div_in      (div_in),
        .high_in     (high_in),
        .sync        (sync),
        .clk_out     (clk_out),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .busy        (busy),
        .cfg_pending (cfg_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 running, 2 finishing its last period.
    int m_mode[NUM_CH];
    int m_pos[NUM_CH];
    int m_per[NUM_CH], m_high[NUM_CH], m_nper[NUM_CH], m_nhigh[NUM_CH];
    bit m_pend[NUM_CH], m_lvl[NUM_CH], m_up[NUM_CH], m_down[NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = 0; m_pos[c] = 0;
            m_per[c] = DEF; m_high[c] = DEF / 2; m_nper[c] = DEF; m_nhigh[c] = DEF / 2;
            m_pend[c] = 0; m_lvl[c] = 0; m_up[c] = 0; m_down[c] = 0;
        end
    endtask

    task automatic m_step();
        for (int c = 0; c < NUM_CH; c++) begin
            int p, h;
            bit was, lvl, period_end;
            p = int'(div_in[c*DW +: DW]);
            h = int'(high_in[c*DW +: DW]);
            if (p < 2) p = 2;
            if (h == 0) h = 1;
            if (h >= p) h = p - 1;
            was = m_lvl[c];
            if (m_mode[c] == 0) begin
                if (load[c]) begin
                    m_per[c] = p; m_high[c] = h; m_nper[c] = p; m_nhigh[c] = h;
                end
                lvl = enable[c];
                if (enable[c]) begin
                    m_mode[c] = 1; m_pos[c] = 0;
                end
            end else begin
                period_end = sync || (m_pos[c] == m_per[c] - 1);
                if (period_end) begin
                    if (m_pend[c]) begin
                        m_per[c] = m_nper[c]; m_high[c] = m_nhigh[c]; m_pend[c] = 0;
                    end
                    m_pos[c] = 0;
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
                lvl = (m_pos[c] < m_high[c]);
                if (enable[c]) m_mode[c] = 1;
                else if (m_mode[c] == 1) m_mode[c] = 2;
                else if (period_end) begin
                    m_mode[c] = 0; m_pos[c] = 0; lvl = 0;
                end
                if (load[c]) begin
                    m_nper[c] = p; m_nhigh[c] = h; m_pend[c] = 1;
                end
            end
            m_up[c] = lvl & !was;
            m_down[c] = !lvl & was;
            m_lvl[c] = lvl;
        end
    endtask

    task automatic compare();
        logic [NUM_CH-1:0] e_clk, e_rise, e_fall, e_busy, e_pend;
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c] = m_lvl[c]; e_rise[c] = m_up[c]; e_fall[c] = m_down[c];
            e_busy[c] = (m_mode[c] != 0); e_pend[c] = m_pend[c];
        end
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("rise_tick", 32'(rise_tick), 32'(e_rise));
        check("fall_tick", 32'(fall_tick), 32'(e_fall));
        check("busy", 32'(busy), 32'(e_busy));
        check("cfg_pending", 32'(cfg_pending), 32'(e_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_reset(); else m_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_load(input int ch, input int p, input int h);
        div_in[ch*DW +: DW] = DW'(p);
        high_in[ch*DW +: DW] = DW'(h);
        load[ch] = 1'b1;
        tick();
        load[ch] = 1'b0;
    endtask

    task automatic wait_rise(input int ch);
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rise_tick[ch]) return;
        end
        check("wait_rise_timeout", 1, 0);
    endtask

    task automatic measure(input int ch, input int per0, input int hi0, output int per, output int hi);
        per = per0; hi = hi0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (rise_tick[ch]) return;
            per++;
            if (clk_out[ch]) hi++;
        end
        check("measure_timeout", 1, 0);
    endtask

    initial begin
        int per, hi, n;
        rst = 1'b1; enable = '0; load = '0; sync = 1'b0; div_in = '0; high_in = '0;
        m_reset();

        // Reset and default period
        repeat (3) tick();
        check("reset_outputs", 32'({clk_out, rise_tick, fall_tick, busy, cfg_pending}), 0);
        rst = 1'b0;
        tick();
        enable[0] = 1'b1;
        tick();
        check("first_rise_clk", 32'(clk_out[0]), 1);
        check("first_rise_tick", 32'(rise_tick[0]), 1);
        measure(0, 1, 1, per, hi);
        check("default_period", per, 10);
        check("default_high", hi, 5);

        // Glitch-free load
        do_load(0, 4, 2);
        wait_rise(0);
        measure(0, 1, 1, per, hi);
        check("p4_period", per, 4);
        check("p4_high", hi, 2);
        do_load(0, 6, 1);
        check("pending_after_load", 32'(cfg_pending[0]), 1);
        measure(0, 2, 2, per, hi);
        check("old_period_kept", per, 4);
        check("old_high_kept", hi, 2);
        check("pending_cleared_at_wrap", 32'(cfg_pending[0]), 0);
        measure(0, 1, 1, per, hi);
        check("p6_period", per, 6);
        check("p6_high", hi, 1);

        // Sanitisation
        do_load(0, 0, 0);
        wait_rise(0);
        measure(0, 1, 1, per, hi);
        check("san_min_period", per, 2);
        check("san_min_high", hi, 1);
        do_load(0, 5, 9);
        wait_rise(0);
        measure(0, 1, 1, per, hi);
        check("san_clamp_period", per, 5);
        check("san_clamp_high", hi, 4);

        // Clean stop and resume
        do_load(0, 8, 4);
        wait_rise(0);
        tick(); tick();
        enable[0] = 1'b0;
        n = 0;
        do begin tick(); n++; end while (busy[0] && n < 50);
        check("stop_cycles", n, 6);
        check("stopped_clk_low", 32'(clk_out[0]), 0);
        enable[0] = 1'b1;
        wait_rise(0);
        tick(); tick();
        enable[0] = 1'b0;
        tick(); tick();
        enable[0] = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!rise_tick[0] && n < 50);
        check("resume_no_gap", n, 4);
        measure(0, 1, 1, per, hi);
        check("resume_period", per, 8);
        check("resume_high", hi, 4);

        // Sync alignment: ch0 high, ch1 low when sync lands
        do_load(0, 4, 2);
        do_load(1, 6, 3);
        enable[1] = 1'b1;
        wait_rise(0);
        n = 0;
        while (clk_out !== 2'b01 && n < 50) begin tick(); n++; end
        check("sync_setup_found", 32'(n < 50), 1);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check("sync_clk_out", 32'(clk_out), 32'(2'b11));
        check("sync_rise_tick", 32'(rise_tick), 32'(2'b10));

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 24) == 0) enable[c] = ~enable[c];
                load[c] = ($urandom_range(0, 14) == 0);
                div_in[c*DW +: DW] = DW'($urandom_range(0, 12));
                high_in[c*DW +: DW] = DW'($urandom_range(0, 14));
            end
            sync = ($urandom_range(0, 39) == 0);
            tick();
        end
        load = '0; sync = 1'b0;

        // Reset mid-operation with a pending config during a high phase
        enable = 2'b01;
        n = 0;
        while (!busy[0] && n < 50) begin tick(); n++; end
        do_load(0, 20, 10);
        wait_rise(0);
        do_load(0, 7, 2);
        check("pre_reset_high", 32'(clk_out[0]), 1);
        check("pre_reset_pending", 32'(cfg_pending[0]), 1);
        rst = 1'b1;
        m_reset();
        #1;
        check("async_reset_outputs", 32'({clk_out, rise_tick, fall_tick, busy, cfg_pending}), 0);
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        wait_rise(0);
        measure(0, 1, 1, per, hi);
        check("post_reset_period", per, 10);
        check("post_reset_high", hi, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
